can_tx_scheduler: RTL and testbench
===================================

CAN_TX_SCHEDULER -- requirements
Module: can_tx_scheduler

Interface
REQ-001 Parameter: NUM_MB, 4, number of transmit mailboxes (2..8).
REQ-002 Parameter: TIMEOUT_CYCLES, 200000, tx_done watchdog limit in clk cycles.
REQ-003 Port: clk  input  1  sole clock, rising edge.
REQ-004 Port: rst  input  1  asynchronous, active-low reset; one clock domain.
REQ-005 Port: mb_req  input  NUM_MB  per-mailbox transmit request, level; held until mb_ack or mb_err.
REQ-006 Port: mb_id  input  NUM_MB*11  packed 11-bit identifiers, mailbox i at [11*i+:11].
REQ-007 Port: mb_dlc  input  NUM_MB*4  packed DLCs, mailbox i at [4*i+:4].
REQ-008 Port: mb_data  input  NUM_MB*64  packed payloads, mailbox i at [64*i+:64].
REQ-009 Port: mb_ack  output  NUM_MB  one-cycle pulse: granted frame completed.
REQ-010 Port: mb_err  output  NUM_MB  one-cycle pulse: granted frame timed out.
REQ-011 Port: tx_start  output  1  one-cycle start pulse to CAN core.
REQ-012 Port: tx_id / tx_dlc / tx_data  output  11 / 4 / 64  registered frame fields to CAN core.
REQ-013 Port: tx_busy  input  1  CAN core busy.
REQ-014 Port: tx_done  input  1  CAN core completion pulse.
REQ-015 Port: grant_idx  output  3  index of mailbox owning the core; valid while sched_busy.
REQ-016 Port: sched_busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, START, WAIT_DONE, ACK; all outputs registered.
REQ-018 IDLE: if any mb_req=1 and tx_busy=0, select winner, latch its id/dlc/data into tx_id/tx_dlc/tx_data, grant_idx=winner, go START.
REQ-019 IDLE with tx_busy=1: no grant; remain IDLE.
REQ-020 Winner = requesting mailbox with numerically lowest mb_id (CAN priority); equal ids -> lowest index.
REQ-021 START: tx_start=1 for exactly this one cycle; next state WAIT_DONE.
REQ-022 Latency: request sampled at edge k -> tx_start high in cycle k+1.
REQ-023 WAIT_DONE: on tx_done=1 go ACK; tx_done in any other state ignored.
REQ-024 ACK: mb_ack[grant_idx]=1 for this one cycle; next state IDLE.
REQ-025 Requester SHALL drop mb_req the cycle after mb_ack; new grant earliest one cycle after ACK.
REQ-026 Mailbox inputs changing after grant SHALL NOT affect tx_id/tx_dlc/tx_data of the frame in flight.
REQ-027 A higher-priority request arriving after grant SHALL NOT preempt; it competes at next IDLE.
REQ-028 mb_ack and mb_err SHALL never both be high; at most one bit of each set per cycle.

Reset
REQ-029 rst=0 SHALL asynchronously force IDLE; tx_start, mb_ack, mb_err, sched_busy, grant_idx, tx_id, tx_dlc, tx_data, watchdog counter all 0.
REQ-030 Reset mid-frame SHALL abandon the grant silently (no ack/err); first post-reset grant earliest one cycle after rst release.

Configuration
REQ-031 Macro CAN_TX_SCHED_TIMEOUT_EN defined: counter clears on entering WAIT_DONE, increments each WAIT_DONE cycle; reaching TIMEOUT_CYCLES without tx_done -> mb_err[grant_idx] one-cycle pulse, go IDLE, no retry, no ack.
REQ-032 tx_done in the same cycle the counter reaches limit SHALL win (ACK, no err).
REQ-033 Macro undefined: no counter logic, mb_err tied 0, WAIT_DONE waits indefinitely.

Structure
REQ-034 Shared package can_pkg SHALL hold CAN_ID_W=11, CAN_DLC_W=4, CAN_DATA_W=64 and the scheduler state encoding.
REQ-035 Winner selection SHALL be a combinational sub-module can_tx_prio_sel (inputs req, packed ids; outputs valid, index).

Verification
REQ-036 Single request: mb_req=0001, id0=0x123, dlc=1, data=0xAA -> tx_start one cycle later with tx_id=0x123, tx_dlc=1, tx_data=0xAA; tx_done -> mb_ack=0001 next cycle.
REQ-037 Priority: mb_req=1111, ids 0x456/0x123/0x7FF/0x124 -> grant order 1,3,0,2; four acks in that order.
REQ-038 Tie: mb_req=0110, id1=id2=0x200 -> mailbox 1 first, then 2.
REQ-039 Busy hold: tx_busy=1 with mb_req=0001 -> no tx_start until tx_busy=0, then tx_start next cycle.
REQ-040 Timeout (macro on, TIMEOUT_CYCLES=50): no tx_done -> mb_err[grant] pulse after 50 WAIT_DONE cycles, mb_ack stays 0; macro off -> sched_busy remains 1.
REQ-041 Reset mid-frame: rst=0 during WAIT_DONE -> all outputs 0 immediately, no ack/err; after release, pending mb_req=0100 is granted normally.

Source files
------------

// File: rtl/can_pkg.sv
// Shared CAN frame field widths and the transmit scheduler state encoding.
package can_pkg;

  localparam int CAN_ID_W   = 11;
  localparam int CAN_DLC_W  = 4;
  localparam int CAN_DATA_W = 64;

  // Wide enough for the largest supported mailbox count (8).
  localparam int MB_IDX_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_START     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_ACK       = 2'd3
  } sched_state_t;

endpackage

// File: rtl/can_tx_prio_sel.sv
// Combinational CAN arbitration: lowest identifier among requesters wins,
// ties resolved toward the lowest mailbox index.
module can_tx_prio_sel
  import can_pkg::*;
#(
  parameter int NUM_MB = 4
) (
  input  logic [NUM_MB-1:0]          req,
  input  logic [NUM_MB*CAN_ID_W-1:0] ids,
  output logic                       valid,
  output logic [MB_IDX_W-1:0]        index
);

  logic [CAN_ID_W-1:0] id_arr [NUM_MB];
  logic [CAN_ID_W-1:0] best_id;

  generate
    for (genvar gi = 0; gi < NUM_MB; gi++) begin : g_unpack
      assign id_arr[gi] = ids[gi*CAN_ID_W +: CAN_ID_W];
    end
  endgenerate

  // Strict less-than keeps the earlier (lower) index on equal identifiers.
  always_comb begin
    valid   = 1'b0;
    index   = '0;
    best_id = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (req[i] && (!valid || (id_arr[i] < best_id))) begin
        valid   = 1'b1;
        index   = MB_IDX_W'(i);
        best_id = id_arr[i];
      end
    end
  end

endmodule

// File: rtl/can_tx_scheduler.sv
// Hands one mailbox frame at a time to the CAN core in identifier-priority order.
// Define CAN_TX_SCHED_TIMEOUT_EN to build the tx_done watchdog (mb_err reporting).
module can_tx_scheduler
  import can_pkg::*;
#(
  parameter int NUM_MB         = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_MB-1:0]            mb_req,
  input  logic [NUM_MB*CAN_ID_W-1:0]   mb_id,
  input  logic [NUM_MB*CAN_DLC_W-1:0]  mb_dlc,
  input  logic [NUM_MB*CAN_DATA_W-1:0] mb_data,
  output logic [NUM_MB-1:0]            mb_ack,
  output logic [NUM_MB-1:0]            mb_err,
  output logic                         tx_start,
  output logic [CAN_ID_W-1:0]          tx_id,
  output logic [CAN_DLC_W-1:0]         tx_dlc,
  output logic [CAN_DATA_W-1:0]        tx_data,
  input  logic                         tx_busy,
  input  logic                         tx_done,
  output logic [MB_IDX_W-1:0]          grant_idx,
  output logic                         sched_busy
);

  sched_state_t state_reg, state_next;

  logic                  start_reg, start_next;
  logic [NUM_MB-1:0]     ack_reg, ack_next;
  logic                  busy_reg, busy_next;
  logic [MB_IDX_W-1:0]   grant_reg, grant_next;
  logic [CAN_ID_W-1:0]   id_reg, id_next;
  logic [CAN_DLC_W-1:0]  dlc_reg, dlc_next;
  logic [CAN_DATA_W-1:0] data_reg, data_next;

  logic                  sel_valid;
  logic [MB_IDX_W-1:0]   sel_idx;
  logic [CAN_ID_W-1:0]   id_sel;
  logic [CAN_DLC_W-1:0]  dlc_sel;
  logic [CAN_DATA_W-1:0] data_sel;
  logic [NUM_MB-1:0]     grant_onehot;
  logic                  err_block;

  can_tx_prio_sel #(
    .NUM_MB (NUM_MB)
  ) u_prio_sel (
    .req   (mb_req),
    .ids   (mb_id),
    .valid (sel_valid),
    .index (sel_idx)
  );

  always_comb begin
    id_sel   = '0;
    dlc_sel  = '0;
    data_sel = '0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (sel_idx == MB_IDX_W'(i)) begin
        id_sel   = mb_id[i*CAN_ID_W +: CAN_ID_W];
        dlc_sel  = mb_dlc[i*CAN_DLC_W +: CAN_DLC_W];
        data_sel = mb_data[i*CAN_DATA_W +: CAN_DATA_W];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_MB; gi++) begin : g_onehot
      assign grant_onehot[gi] = (grant_reg == MB_IDX_W'(gi));
    end
  endgenerate

`ifdef CAN_TX_SCHED_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_reg, wdog_next;
  logic [NUM_MB-1:0] err_reg, err_next;
  logic              wdog_expire;

  // Expires on the WAIT_DONE cycle in which the count reaches the limit.
  assign wdog_expire = (wdog_reg == WDOG_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wdog_next = wdog_reg;
    if (state_reg == ST_START) begin
      wdog_next = '0;
    end else if (state_reg == ST_WAIT_DONE) begin
      wdog_next = wdog_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wdog_reg <= '0;
      err_reg  <= '0;
    end else begin
      wdog_reg <= wdog_next;
      err_reg  <= err_next;
    end
  end

  // The failed requester still holds mb_req during its error pulse; never re-grant it then.
  assign err_block = |err_reg;
  assign mb_err    = err_reg;
`else
  assign err_block = 1'b0;
  assign mb_err    = '0;
`endif

  always_comb begin
    state_next = state_reg;
    start_next = 1'b0;
    ack_next   = '0;
    grant_next = grant_reg;
    id_next    = id_reg;
    dlc_next   = dlc_reg;
    data_next  = data_reg;
`ifdef CAN_TX_SCHED_TIMEOUT_EN
    err_next   = '0;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (sel_valid && !tx_busy && !err_block) begin
          grant_next = sel_idx;
          id_next    = id_sel;
          dlc_next   = dlc_sel;
          data_next  = data_sel;
          start_next = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START: begin
        state_next = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (tx_done) begin
          ack_next   = grant_onehot;
          state_next = ST_ACK;
        end
`ifdef CAN_TX_SCHED_TIMEOUT_EN
        else if (wdog_expire) begin
          err_next   = grant_onehot;
          state_next = ST_IDLE;
        end
`endif
      end
      ST_ACK: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
    busy_next = (state_next != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      start_reg <= 1'b0;
      ack_reg   <= '0;
      busy_reg  <= 1'b0;
      grant_reg <= '0;
      id_reg    <= '0;
      dlc_reg   <= '0;
      data_reg  <= '0;
    end else begin
      state_reg <= state_next;
      start_reg <= start_next;
      ack_reg   <= ack_next;
      busy_reg  <= busy_next;
      grant_reg <= grant_next;
      id_reg    <= id_next;
      dlc_reg   <= dlc_next;
      data_reg  <= data_next;
    end
  end

  assign tx_start   = start_reg;
  assign mb_ack     = ack_reg;
  assign sched_busy = busy_reg;
  assign grant_idx  = grant_reg;
  assign tx_id      = id_reg;
  assign tx_dlc     = dlc_reg;
  assign tx_data    = data_reg;

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Directed and randomized checks of can_tx_scheduler against a priority-queue style reference model.
module tb_can_tx_scheduler;

  localparam int NUM_MB  = 4;
  localparam int TIMEOUT = 50;
`ifdef CAN_TX_SCHED_TIMEOUT_EN
  localparam int HOLD_CYCLES = 20;
`else
  localparam int HOLD_CYCLES = 60;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NUM_MB-1:0]      mb_req;
  logic [NUM_MB*11-1:0]   mb_id;
  logic [NUM_MB*4-1:0]    mb_dlc;
  logic [NUM_MB*64-1:0]   mb_data;
  logic [NUM_MB-1:0]      mb_ack;
  logic [NUM_MB-1:0]      mb_err;
  logic                   tx_start;
  logic [10:0]            tx_id;
  logic [3:0]             tx_dlc;
  logic [63:0]            tx_data;
  logic                   tx_busy;
  logic                   tx_done;
  logic [2:0]             grant_idx;
  logic                   sched_busy;

  always #5 clk = ~clk;

  can_tx_scheduler #(
    .NUM_MB         (NUM_MB),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mb_req     (mb_req),
    .mb_id      (mb_id),
    .mb_dlc     (mb_dlc),
    .mb_data    (mb_data),
    .mb_ack     (mb_ack),
    .mb_err     (mb_err),
    .tx_start   (tx_start),
    .tx_id      (tx_id),
    .tx_dlc     (tx_dlc),
    .tx_data    (tx_data),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done),
    .grant_idx  (grant_idx),
    .sched_busy (sched_busy)
  );

  // Reference model: pending mailboxes and their contents.
  logic        m_req  [NUM_MB];
  logic [10:0] m_id   [NUM_MB];
  logic [3:0]  m_dlc  [NUM_MB];
  logic [63:0] m_data [NUM_MB];

  logic [10:0] fl_id;
  logic [3:0]  fl_dlc;
  logic [63:0] fl_data;
  int          order_q[$];
  int          n_pass  = 0;
  int          n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("ack_err_exclusive",
        64'(((mb_ack & mb_err) == '0) && ($countones(mb_ack) <= 1) && ($countones(mb_err) <= 1)), 64'd1);
  endtask

  // Winner = smallest (id, index) pair among pending mailboxes.
  function automatic int model_winner();
    int best     = -1;
    int best_key = 0;
    for (int i = 0; i < NUM_MB; i++) begin
      if (m_req[i]) begin
        int key = int'(m_id[i]) * NUM_MB + i;
        if (best < 0 || key < best_key) begin
          best     = i;
          best_key = key;
        end
      end
    end
    return best;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NUM_MB; i++) begin
      mb_req[i]          = m_req[i];
      mb_id[i*11 +: 11]  = m_id[i];
      mb_dlc[i*4 +: 4]   = m_dlc[i];
      mb_data[i*64 +: 64] = m_data[i];
    end
  endtask

  task automatic set_mb(input int i, input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
    m_req[i]  = 1'b1;
    m_id[i]   = id;
    m_dlc[i]  = dlc;
    m_data[i] = data;
  endtask

  task automatic add_random_request();
    int i = $urandom_range(0, NUM_MB - 1);
    if (!m_req[i]) begin
      set_mb(i, ($urandom_range(0, 1) == 1) ? 11'($urandom_range(0, 7)) : 11'($urandom_range(0, 2047)),
             4'($urandom_range(0, 8)), {$urandom, $urandom});
    end
  endtask

  // Drive current requests; the next edge must produce the grant of mailbox exp.
  task automatic check_grant(input int exp);
    drive_inputs();
    tick();
    chk("tx_start", 64'(tx_start), 64'd1);
    chk("grant_idx", 64'(grant_idx), 64'(exp));
    chk("tx_id", 64'(tx_id), 64'(m_id[exp]));
    chk("tx_dlc", 64'(tx_dlc), 64'(m_dlc[exp]));
    chk("tx_data", tx_data, m_data[exp]);
    chk("sched_busy_start", 64'(sched_busy), 64'd1);
    fl_id   = m_id[exp];
    fl_dlc  = m_dlc[exp];
    fl_data = m_data[exp];
    order_q.push_back(exp);
    tick();
    chk("tx_start_pulse", 64'(tx_start), 64'd0);
  endtask

  task automatic finish_frame(input int idx, input int delay, input bit arrivals);
    repeat (delay) begin
      if (arrivals && $urandom_range(0, 2) == 0) add_random_request();
      drive_inputs();
      tick();
    end
    chk("tx_id_hold", 64'(tx_id), 64'(fl_id));
    chk("tx_data_hold", tx_data, fl_data);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("mb_ack", 64'(mb_ack), 64'(1) << idx);
    chk("mb_err_on_ack", 64'(mb_err), 64'd0);
    tick();
    chk("mb_ack_pulse", 64'(mb_ack), 64'd0);
    chk("idle_after_ack", 64'(sched_busy), 64'd0);
    m_req[idx] = 1'b0;
    drive_inputs();
  endtask

  task automatic serve_all(input bit arrivals);
    int w = model_winner();
    while (w >= 0) begin
      check_grant(w);
      finish_frame(w, $urandom_range(0, 4), arrivals);
      w = model_winner();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int  w;
    bit  ok;
    int  exp_prio[4] = '{1, 3, 0, 2};
    int  exp_tie[2]  = '{1, 2};

    for (int i = 0; i < NUM_MB; i++) begin
      m_req[i] = 1'b0; m_id[i] = '0; m_dlc[i] = '0; m_data[i] = '0;
    end
    drive_inputs();
    tx_busy = 1'b0;
    tx_done = 1'b0;
    rst     = 1'b1;
    #3 rst  = 1'b0;
    #1;
    chk("rst_tx_start", 64'(tx_start), 64'd0);
    chk("rst_busy", 64'(sched_busy), 64'd0);
    tick();
    tick();
    chk("rst_grant_idx", 64'(grant_idx), 64'd0);
    chk("rst_tx_id", 64'(tx_id), 64'd0);
    chk("rst_tx_dlc", 64'(tx_dlc), 64'd0);
    chk("rst_tx_data", tx_data, 64'd0);
    chk("rst_mb_ack", 64'(mb_ack), 64'd0);
    chk("rst_mb_err", 64'(mb_err), 64'd0);
    rst = 1'b1;
    tick();

    // Single request with fixed frame contents.
    set_mb(0, 11'h123, 4'd1, 64'hAA);
    check_grant(0);
    chk("single_id_const", 64'(tx_id), 64'h123);
    chk("single_data_const", tx_data, 64'hAA);
    finish_frame(0, 2, 1'b0);

    // Priority order.
    set_mb(0, 11'h456, 4'd2, 64'h1000);
    set_mb(1, 11'h123, 4'd3, 64'h1001);
    set_mb(2, 11'h7FF, 4'd4, 64'h1002);
    set_mb(3, 11'h124, 4'd5, 64'h1003);
    order_q.delete();
    serve_all(1'b0);
    for (int k = 0; k < 4; k++) chk("prio_order", 64'(order_q[k]), 64'(exp_prio[k]));

    // Equal identifiers.
    set_mb(1, 11'h200, 4'd6, 64'h2001);
    set_mb(2, 11'h200, 4'd7, 64'h2002);
    order_q.delete();
    serve_all(1'b0);
    for (int k = 0; k < 2; k++) chk("tie_order", 64'(order_q[k]), 64'(exp_tie[k]));

    // Core busy holds off the grant.
    set_mb(0, 11'h055, 4'd8, 64'h3000);
    tx_busy = 1'b1;
    drive_inputs();
    ok = 1'b1;
    repeat (5) begin
      tick();
      if (tx_start !== 1'b0 || sched_busy !== 1'b0) ok = 1'b0;
    end
    chk("busy_hold", 64'(ok), 64'd1);
    tx_busy = 1'b0;
    check_grant(0);
    finish_frame(0, 1, 1'b0);

    // In-flight frame is frozen and not preempted.
    set_mb(2, 11'h300, 4'd3, 64'hDEAD_BEEF_0000_0002);
    check_grant(2);
    m_id[2]   = 11'h001;
    m_data[2] = 64'h0;
    set_mb(0, 11'h002, 4'd1, 64'h4000);
    drive_inputs();
    tick();
    chk("no_preempt_grant", 64'(grant_idx), 64'd2);
    finish_frame(2, 2, 1'b0);
    check_grant(0);
    finish_frame(0, 0, 1'b0);

    // Randomized traffic with arrivals during frames.
    repeat (40) begin
      for (int k = 0; k < 2; k++) if ($urandom_range(0, 1) == 1) add_random_request();
      while (model_winner() < 0) add_random_request();
      w = model_winner();
      check_grant(w);
      finish_frame(w, $urandom_range(0, 4), 1'b1);
    end
    serve_all(1'b0);

`ifdef CAN_TX_SCHED_TIMEOUT_EN
    // Watchdog expiry, then tx_done on the limit cycle.
    set_mb(3, 11'h010, 4'd2, 64'h5000);
    check_grant(3);
    ok = 1'b1;
    repeat (TIMEOUT - 1) begin
      tick();
      if (mb_err !== '0 || mb_ack !== '0 || sched_busy !== 1'b1) ok = 1'b0;
    end
    chk("wdog_quiet", 64'(ok), 64'd1);
    tick();
    chk("wdog_err", 64'(mb_err), 64'b1000);
    chk("wdog_no_ack", 64'(mb_ack), 64'd0);
    chk("wdog_idle", 64'(sched_busy), 64'd0);
    tick();
    chk("wdog_err_pulse", 64'(mb_err), 64'd0);
    chk("wdog_no_retry", 64'(tx_start), 64'd0);
    m_req[3] = 1'b0;
    drive_inputs();
    tick();
    chk("wdog_no_retry2", 64'(tx_start), 64'd0);
    set_mb(3, 11'h011, 4'd3, 64'h5001);
    check_grant(3);
    repeat (TIMEOUT - 1) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    chk("wdog_edge_ack", 64'(mb_ack), 64'b1000);
    chk("wdog_edge_err", 64'(mb_err), 64'd0);
    tick();
    m_req[3] = 1'b0;
    drive_inputs();
`endif

    // Frame held without tx_done, then abandoned by reset.
    set_mb(1, 11'h050, 4'd4, 64'h6000);
    check_grant(1);
    ok = 1'b1;
    repeat (HOLD_CYCLES) begin
      tick();
      if (sched_busy !== 1'b1 || mb_err !== '0 || mb_ack !== '0) ok = 1'b0;
    end
    chk("wait_done_hold", 64'(ok), 64'd1);
    #2 rst = 1'b0;
    m_req[1] = 1'b0;
    set_mb(2, 11'h600, 4'd5, 64'h7000);
    drive_inputs();
    #1;
    chk("midrst_tx_start", 64'(tx_start), 64'd0);
    chk("midrst_busy", 64'(sched_busy), 64'd0);
    chk("midrst_grant", 64'(grant_idx), 64'd0);
    chk("midrst_tx_id", 64'(tx_id), 64'd0);
    chk("midrst_tx_dlc", 64'(tx_dlc), 64'd0);
    chk("midrst_tx_data", tx_data, 64'd0);
    tick();
    tick();
    chk("midrst_no_ack", 64'(mb_ack), 64'd0);
    chk("midrst_no_err", 64'(mb_err), 64'd0);
    rst = 1'b1;
    check_grant(2);
    finish_frame(2, 2, 1'b0);

    // tx_done outside WAIT_DONE is ignored.
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    tick();
    chk("stray_done_ack", 64'(mb_ack), 64'd0);
    chk("stray_done_busy", 64'(sched_busy), 64'd0);
    chk("stray_done_start", 64'(tx_start), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
